// File: rtl/mpc_mul_share_arbiter_pkg.sv
// Shared constants and types for the shared-multiplier arbiter.
// Operand widths are fixed; requester count and pipe depth are top-level parameters.
package mpc_mul_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  localparam int A_W         = 21;
  localparam int B_W         = 14;
  localparam int P_W         = A_W + B_W + 1;
  localparam int NREQ_DEF    = 4;
  localparam int MUL_LAT_DEF = 3;
  localparam int ID_W        = clog2(NREQ_DEF);

  typedef logic [ID_W-1:0] req_idx_t;

endpackage

// File: rtl/mpc_mul_share_arbiter_if.sv
// Requester and result handshake bundle for the shared multiplier.
// Master is the requester/consumer side, slave is the arbiter.
interface mpc_mul_share_arbiter_if #(
  parameter int NREQ    = mpc_mul_pkg::NREQ_DEF,
  parameter int MUL_LAT = mpc_mul_pkg::MUL_LAT_DEF
);
  import mpc_mul_pkg::*;
  localparam int IDW  = clog2(NREQ);
  localparam int CNTW = clog2(MUL_LAT + 1);

  logic [NREQ-1:0]     req_valid;
  logic [NREQ*A_W-1:0] req_a;
  logic [NREQ*B_W-1:0] req_b;
  logic [NREQ-1:0]     req_ready;
  logic                res_valid;
  logic                res_ready;
  logic [P_W-1:0]      res_p;
  logic [IDW-1:0]      res_id;
  logic [CNTW-1:0]     inflight;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_p, res_id, inflight
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_p, res_id, inflight
  );
endinterface

// File: rtl/mpc_mul_share_arbiter_pipe.sv
// MUL_LAT-deep signed x unsigned multiply pipe; first stage captures operands.
// Every stage advances only on ce; data carries no reset.
module mpc_mul_pipe
  import mpc_mul_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  ce,
  input  logic signed [A_W-1:0] a,
  input  logic        [B_W-1:0] b,
  output logic signed [P_W-1:0] p
);
  logic signed [A_W-1:0] a_q, a_d;
  logic        [B_W-1:0] b_q, b_d;
  logic signed [P_W-1:0] p_q [MUL_LAT-1];
  logic signed [P_W-1:0] p_d [MUL_LAT-1];

  always_comb begin
    a_d = ce ? a : a_q;
    b_d = ce ? b : b_q;
    // b is zero-extended so it multiplies as a non-negative signed value
    p_d[0] = ce ? P_W'(a_q) * P_W'($signed({1'b0, b_q})) : p_q[0];
    for (int i = 1; i < MUL_LAT - 1; i++)
      p_d[i] = ce ? p_q[i-1] : p_q[i];
  end

  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
    p_q <= p_d;
  end

  assign p = p_q[MUL_LAT-2];
endmodule

// File: rtl/mpc_mul_share_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier among NREQ requesters.
// Tag/valid shift register tracks the data pipe; a single stall freezes everything.
module mpc_mul_share_arbiter
  import mpc_mul_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input logic clk,
  input logic rst,
  mpc_mul_share_arbiter_if.slave bus
);
  localparam int IDW  = clog2(NREQ);
  localparam int CNTW = clog2(MUL_LAT + 1);

  logic [IDW-1:0]               rr_q, rr_d;
  logic [MUL_LAT-1:0]           vld_q, vld_d;
  logic [MUL_LAT-1:0][IDW-1:0]  tag_q, tag_d;
  logic [CNTW-1:0]              inflight_q, inflight_d;
  logic [NREQ-1:0]              gnt;
  logic [IDW-1:0]               g;
  logic                         found, ce, res_valid;
  logic signed [A_W-1:0]        a_sel;
  logic        [B_W-1:0]        b_sel;
  int                           idx;

  // Gated by rst so nothing leaks out (or stalls) during the reset cycle
  assign res_valid = vld_q[MUL_LAT-1] & ~rst;
  assign ce        = ~(res_valid & ~bus.res_ready);

  always_comb begin
    gnt   = '0;
    g     = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && ce && !rst && bus.req_valid[idx]) begin
        found    = 1'b1;
        g        = IDW'(idx);
        gnt[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    a_sel = bus.req_a[g*A_W +: A_W];
    b_sel = bus.req_b[g*B_W +: B_W];
    rr_d  = rr_q;
    if (found) rr_d = (int'(g) == NREQ - 1) ? '0 : g + 1'b1;
    vld_d = vld_q;
    tag_d = tag_q;
    if (ce) begin
      vld_d = {vld_q[MUL_LAT-2:0], found};
      tag_d = {tag_q[MUL_LAT-2:0], g};
    end
    inflight_d = inflight_q + CNTW'(found) - CNTW'(res_valid & bus.res_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q       <= '0;
      vld_q      <= '0;
      tag_q      <= '0;
      inflight_q <= '0;
    end else begin
      rr_q       <= rr_d;
      vld_q      <= vld_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end
  end

  mpc_mul_pipe #(.MUL_LAT(MUL_LAT)) u_pipe (
    .clk (clk),
    .ce  (ce),
    .a   (a_sel),
    .b   (b_sel),
    .p   (bus.res_p)
  );

  assign bus.req_ready = gnt;
  assign bus.res_valid = res_valid;
  assign bus.res_id    = tag_q[MUL_LAT-1];
  assign bus.inflight  = inflight_q;
endmodule

// File: tb/tb_mpc_mul_share_arbiter.sv
// Scoreboarded bench: the stimulus side predicts grants/latency and queues
// expected products; a separate monitor checks every presented result.
module tb_mpc_mul_share_arbiter;
  import mpc_mul_pkg::*;
  localparam int NREQ = 4;
  localparam int LAT  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mpc_mul_share_arbiter_if #(.NREQ(NREQ), .MUL_LAT(LAT)) bus ();
  mpc_mul_share_arbiter #(.NREQ(NREQ), .MUL_LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    req_idx_t              id;
    logic signed [P_W-1:0] p;
  } exp_t;

  exp_t exp_q[$];
  int   errs = 0, checks = 0;

  logic signed [A_W-1:0] va [NREQ];
  logic        [B_W-1:0] vb [NREQ];
  logic [NREQ-1:0]       vv;
  logic                  rdy;

  // reference state: rotating priority start, outstanding count, result timing
  int rr = 0, infl = 0, g_last = 0;
  bit occ [LAT];
  bit acc_last = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic signed [A_W-1:0] rand_a();
    case ($urandom_range(7))
      0:       return {1'b1, {(A_W-1){1'b0}}};
      1:       return {1'b0, {(A_W-1){1'b1}}};
      2:       return '0;
      default: return A_W'($urandom);
    endcase
  endfunction

  function automatic logic [B_W-1:0] rand_b();
    case ($urandom_range(5))
      0:       return '1;
      1:       return '0;
      default: return B_W'($urandom);
    endcase
  endfunction

  // One clock: drive, check predictions mid-cycle, then advance the model
  task automatic tick();
    logic [NREQ-1:0] eg;
    int  g;
    bit  found, ev, stall;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*A_W +: A_W] = va[i];
      bus.req_b[i*B_W +: B_W] = vb[i];
    end
    bus.req_valid = vv;
    bus.res_ready = rdy;
    @(negedge clk);
    ev    = !rst && occ[LAT-1];
    stall = ev && !rdy;
    eg    = '0;
    found = 1'b0;
    g     = 0;
    if (!rst && !stall)
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (rr + k) % NREQ;
        if (!found && vv[i]) begin
          found = 1'b1;
          g     = i;
          eg[i] = 1'b1;
        end
      end
    chk("req_ready", 64'(bus.req_ready), 64'(eg));
    chk("res_valid", 64'(bus.res_valid), 64'(ev));
    chk("inflight", 64'(bus.inflight), 64'(infl));
    @(posedge clk);
    if (rst) begin
      rr       = 0;
      infl     = 0;
      occ      = '{default: 1'b0};
      acc_last = 1'b0;
      exp_q.delete();
    end else begin
      if (ev && rdy) infl--;
      if (!stall) begin
        for (int s = LAT - 1; s > 0; s--) occ[s] = occ[s-1];
        occ[0] = found;
      end
      if (found) begin
        exp_q.push_back('{id: req_idx_t'(g),
                          p:  P_W'(longint'(va[g]) * longint'(vb[g]))});
        rr = (g + 1) % NREQ;
        infl++;
      end
      acc_last = found;
      g_last   = g;
    end
    #1;
  endtask

  task automatic regen();
    if (acc_last) begin
      va[g_last] = rand_a();
      vb[g_last] = rand_b();
    end
  endtask

  task automatic next_ops(input int pct);
    for (int i = 0; i < NREQ; i++) begin
      if (!vv[i] || (acc_last && g_last == i)) begin
        vv[i] = ($urandom_range(99) < pct);
        va[i] = rand_a();
        vb[i] = rand_b();
      end else if ($urandom_range(9) == 0) begin
        vv[i] = 1'b0;
      end
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (bus.res_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL res_unexpected: got id %0d p %0h with nothing outstanding", bus.res_id, bus.res_p);
        end else begin
          chk("res_p", 64'($signed(bus.res_p)), 64'(exp_q[0].p));
          chk("res_id", 64'(bus.res_id), 64'(exp_q[0].id));
          if (bus.res_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    vv  = '0;
    rdy = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      va[i] = '0;
      vb[i] = '0;
    end
    repeat (2) tick();
    rst = 1'b0;

    // single request, latency and inflight
    vv = 4'b0001; va[0] = -21'sd3; vb[0] = 14'd5;
    tick();
    vv = '0;
    repeat (4) tick();

    // operand extremes from two requesters
    vv = 4'b0011;
    va[0] = {1'b1, {(A_W-1){1'b0}}}; vb[0] = '1;
    va[1] = {1'b0, {(A_W-1){1'b1}}}; vb[1] = '1;
    repeat (2) begin
      tick();
      if (acc_last) vv[g_last] = 1'b0;
    end
    vv = '0;
    repeat (4) tick();

    // all requesters busy, then backpressure with three in flight
    vv = '1;
    for (int i = 0; i < NREQ; i++) begin
      va[i] = rand_a();
      vb[i] = rand_b();
    end
    repeat (3) begin tick(); regen(); end
    rdy = 1'b0;
    repeat (5) begin tick(); regen(); end
    rdy = 1'b1;
    repeat (4) begin tick(); regen(); end
    vv = '0;
    repeat (5) tick();

    // sparse traffic from requester 2
    vv = 4'b0100; va[2] = rand_a(); vb[2] = rand_b();
    tick();
    vv = '0;
    repeat (3) tick();
    vv = 4'b0100; va[2] = rand_a(); vb[2] = rand_b();
    tick();
    vv = '0;
    repeat (5) tick();

    // reset with two operations in flight
    vv = 4'b0001; tick();
    vv = 4'b0010; tick();
    vv = '0; rst = 1'b1; tick();
    rst = 1'b0;
    repeat (LAT + 2) tick();
    vv = '1; tick();
    vv = '0;
    repeat (LAT + 2) tick();

    // randomized traffic with random backpressure
    repeat (2000) begin
      rdy = ($urandom_range(3) != 0);
      next_ops(60);
      tick();
    end
    vv  = '0;
    rdy = 1'b1;
    repeat (LAT + 3) tick();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
